// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt unit: mstatus/mie/mtvec/mepc/mcause/mip, source
// synchronisers, fixed-priority cause arbitration and ISR target. CSR_MCYCLE_EN adds mcycle.
module csr_irq_unit #(
    parameter int                 NUM_IRQ       = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = 4'b0001,
    parameter int                 PC_W          = 16,
    parameter int                 SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq_timer,
    input  logic               irq_ext,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         exceptions,
    input  logic               trap_enter,
    input  logic               mret,
    input  logic [PC_W-1:0]    pc,
    output logic               interrupt_pending,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    input  logic               csr_we,
    output logic [31:0]        csr_rdata,
    output logic [PC_W-1:0]    isr_return,
    output logic [PC_W-1:0]    isr_target
);

    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_prev;
    logic [NUM_IRQ-1:0]     in_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0]     in_prev;
    logic                   ext_rise;
    logic [NUM_IRQ-1:0]     in_rise;

    logic               st_mie, st_mpie;
    logic [31:0]        mie_q, mtvec_q, mepc_q, mcause_q;
    logic               tmr_pend, ext_pend;
    logic [NUM_IRQ-1:0] edge_pend;

    logic [31:0] mip_view, eligible;
    logic        take_valid, take_irq;
    logic [4:0]  take_code;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;

    assign wr_mstatus = csr_we && (csr_addr == 12'h300);
    assign wr_mie     = csr_we && (csr_addr == 12'h304);
    assign wr_mtvec   = csr_we && (csr_addr == 12'h305);
    assign wr_mepc    = csr_we && (csr_addr == 12'h341);
    assign wr_mcause  = csr_we && (csr_addr == 12'h342);
    assign wr_mip     = csr_we && (csr_addr == 12'h344);

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_sync <= '0;
            ext_prev <= 1'b0;
            in_prev  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) in_sync[s] <= '0;
        end else begin
            ext_sync   <= {ext_sync[SYNC_STAGES-2:0], irq_ext};
            ext_prev   <= ext_sync[SYNC_STAGES-1];
            in_sync[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) in_sync[s] <= in_sync[s-1];
            in_prev    <= in_sync[SYNC_STAGES-1];
        end
    end

    assign ext_rise = ext_sync[SYNC_STAGES-1] & ~ext_prev;
    assign in_rise  = in_sync[SYNC_STAGES-1] & ~in_prev & IRQ_EDGE_MASK;

    // Level sources bypass the pending registers so they appear SYNC_STAGES cycles after the pin.
    always_comb begin
        mip_view     = '0;
        mip_view[7]  = tmr_pend;
        mip_view[11] = ext_pend;
        for (int i = 0; i < NUM_IRQ; i++)
            mip_view[16+i] = IRQ_EDGE_MASK[i] ? edge_pend[i] : in_sync[SYNC_STAGES-1][i];
    end

    assign eligible          = mie_q & mip_view & {32{st_mie}};
    assign interrupt_pending = |eligible;

    always_comb begin
        take_valid = 1'b0;
        take_irq   = 1'b0;
        take_code  = '0;
        if (eligible[11]) begin
            take_valid = 1'b1;
            take_irq   = 1'b1;
            take_code  = 5'd11;
        end else if (|eligible[16 +: NUM_IRQ]) begin
            take_valid = 1'b1;
            take_irq   = 1'b1;
            for (int i = NUM_IRQ - 1; i >= 0; i--)
                if (eligible[16+i]) take_code = 5'(16 + i);
        end else if (eligible[7]) begin
            take_valid = 1'b1;
            take_irq   = 1'b1;
            take_code  = 5'd7;
        end else if (exceptions[1]) begin
            take_valid = 1'b1;
            take_code  = 5'd2;
        end else if (exceptions[0]) begin
            take_valid = 1'b1;
            take_code  = 5'd0;
        end else if (exceptions[2]) begin
            take_valid = 1'b1;
            take_code  = 5'd5;
        end
    end

    // Trap entry beats mret, and both beat a software write to mstatus.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (trap_enter) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q    <= '0;
            mtvec_q  <= 32'h1;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (wr_mie)   mie_q   <= csr_wdata;
            if (wr_mtvec) mtvec_q <= csr_wdata;
            if (trap_enter)   mepc_q <= 32'(pc) & ~32'h1;
            else if (wr_mepc) mepc_q <= csr_wdata & ~32'h1;
            if (trap_enter) begin
                if (take_valid) mcause_q <= {take_irq, 26'b0, take_code};
            end else if (wr_mcause) begin
                mcause_q <= csr_wdata;
            end
        end
    end

    // Sticky bits: a new edge beats the clear from trap entry, which beats a software write.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            edge_pend <= '0;
        end else begin
            tmr_pend <= irq_timer;
            if (ext_rise)
                ext_pend <= 1'b1;
            else if (trap_enter && take_irq && take_code == 5'd11)
                ext_pend <= 1'b0;
            else if (wr_mip)
                ext_pend <= csr_wdata[11];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (!IRQ_EDGE_MASK[i])
                    edge_pend[i] <= 1'b0;
                else if (in_rise[i])
                    edge_pend[i] <= 1'b1;
                else if (trap_enter && take_irq && take_code == 5'(16 + i))
                    edge_pend[i] <= 1'b0;
                else if (wr_mip)
                    edge_pend[i] <= csr_wdata[16+i];
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q;

    always_ff @(posedge clk) begin
        if (reset)
            mcycle_q <= '0;
        else if (csr_we && csr_addr == 12'hB00)
            mcycle_q[31:0] <= csr_wdata;
        else if (csr_we && csr_addr == 12'hB80)
            mcycle_q[63:32] <= csr_wdata;
        else
            mcycle_q <= mcycle_q + 64'd1;
    end
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = mip_view;
`ifdef CSR_MCYCLE_EN
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
`endif
            default: csr_rdata = '0;
        endcase
    end

    assign isr_return = mepc_q[PC_W-1:0];
    // Only interrupt causes are vectored; exceptions always land on the base.
    assign isr_target = PC_W'({mtvec_q[31:2], 2'b00} +
                              ((mtvec_q[1:0] == 2'b01 && mcause_q[31]) ? {mcause_q[29:0], 2'b00} : 32'h0));

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_csr_irq_unit;
    localparam int              NUM_IRQ     = 4;
    localparam int              PC_W        = 16;
    localparam int              SYNC_STAGES = 2;
    localparam logic [NUM_IRQ-1:0] EDGE_MASK = 4'b0001;

    logic               clk, reset;
    logic               irq_timer, irq_ext;
    logic [NUM_IRQ-1:0] irq_in;
    logic [2:0]         exceptions;
    logic               trap_enter, mret;
    logic [PC_W-1:0]    pc;
    logic               interrupt_pending;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic               csr_we;
    logic [31:0]        csr_rdata;
    logic [PC_W-1:0]    isr_return, isr_target;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    csr_irq_unit #(
        .NUM_IRQ(NUM_IRQ), .IRQ_EDGE_MASK(EDGE_MASK), .PC_W(PC_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_in(irq_in),
        .exceptions(exceptions), .trap_enter(trap_enter), .mret(mret), .pc(pc),
        .interrupt_pending(interrupt_pending), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_we(csr_we), .csr_rdata(csr_rdata), .isr_return(isr_return), .isr_target(isr_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                 m_mie_en, m_mpie, m_tmr, m_ext;
    logic [31:0]        m_mie, m_mtvec, m_mepc, m_mcause;
    logic [NUM_IRQ-1:0] m_edge;
    logic [63:0]        m_cyc;
    bit                 ext_h[$];
    logic [NUM_IRQ-1:0] in_h[$];
    logic [NUM_IRQ-1:0] em = EDGE_MASK;

    function automatic logic [31:0] m_mip();
        logic [31:0] v;
        v     = 32'h0;
        v[7]  = m_tmr;
        v[11] = m_ext;
        for (int i = 0; i < NUM_IRQ; i++)
            v[16+i] = em[i] ? m_edge[i] : in_h[SYNC_STAGES-1][i];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) << 7) | (32'(m_mie_en) << 3);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [PC_W-1:0] m_target();
        logic [31:0] t;
        t = m_mtvec & ~32'h3;
        if (m_mtvec[1:0] == 2'b01 && m_mcause[31]) t = t + 4 * (m_mcause & 32'h7FFF_FFFF);
        return t[PC_W-1:0];
    endfunction

    always @(posedge clk) begin
        logic [31:0] el, d;
        bit          valid, is_irq, ext_rise, wmip;
        int          code;
        if (reset) begin
            m_mie_en = 0; m_mpie = 0; m_tmr = 0; m_ext = 0;
            m_mie = 0; m_mtvec = 32'h1; m_mepc = 0; m_mcause = 0; m_edge = 0; m_cyc = 0;
            ext_h.delete();
            in_h.delete();
            repeat (SYNC_STAGES + 1) begin
                ext_h.push_back(1'b0);
                in_h.push_back('0);
            end
            started = 1;
        end else begin
            el = m_mie & m_mip() & {32{m_mie_en}};
            valid = 0; is_irq = 0; code = 0;
            if (el[11]) begin valid = 1; is_irq = 1; code = 11; end
            for (int i = 0; i < NUM_IRQ; i++)
                if (!valid && el[16+i]) begin valid = 1; is_irq = 1; code = 16 + i; end
            if (!valid && el[7]) begin valid = 1; is_irq = 1; code = 7; end
            if (!valid) begin
                if (exceptions[1])      begin valid = 1; code = 2; end
                else if (exceptions[0]) begin valid = 1; code = 0; end
                else if (exceptions[2]) begin valid = 1; code = 5; end
            end
            d    = csr_wdata;
            wmip = csr_we && csr_addr == 12'h344;
            ext_rise = ext_h[SYNC_STAGES-1] && !ext_h[SYNC_STAGES];
            m_tmr = irq_timer;
            if (ext_rise) m_ext = 1;
            else if (trap_enter && is_irq && code == 11) m_ext = 0;
            else if (wmip) m_ext = d[11];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (!em[i]) m_edge[i] = 0;
                else if (in_h[SYNC_STAGES-1][i] && !in_h[SYNC_STAGES][i]) m_edge[i] = 1;
                else if (trap_enter && is_irq && code == 16 + i) m_edge[i] = 0;
                else if (wmip) m_edge[i] = d[16+i];
            end
            if (trap_enter) begin
                m_mpie = m_mie_en; m_mie_en = 0;
                m_mepc = 32'(pc) & ~32'h1;
                if (valid) m_mcause = (is_irq ? 32'h8000_0000 : 32'h0) | 32'(code);
            end else begin
                if (mret) begin m_mie_en = m_mpie; m_mpie = 1; end
                else if (csr_we && csr_addr == 12'h300) begin m_mie_en = d[3]; m_mpie = d[7]; end
                if (csr_we && csr_addr == 12'h341) m_mepc = d & ~32'h1;
                if (csr_we && csr_addr == 12'h342) m_mcause = d;
            end
            if (csr_we && csr_addr == 12'h304) m_mie = d;
            if (csr_we && csr_addr == 12'h305) m_mtvec = d;
            if (csr_we && csr_addr == 12'hB00) m_cyc[31:0] = d;
            else if (csr_we && csr_addr == 12'hB80) m_cyc[63:32] = d;
            else m_cyc = m_cyc + 1;
            ext_h.push_front(irq_ext);
            void'(ext_h.pop_back());
            in_h.push_front(irq_in);
            void'(in_h.pop_back());
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            check("irq_pending", 32'(interrupt_pending),
                  32'(|(m_mie & m_mip()) && m_mie_en));
            check("isr_return", 32'(isr_return), 32'(m_mepc[PC_W-1:0]));
            check("isr_target", 32'(isr_target), 32'(m_target()));
            check("csr_rdata", csr_rdata, m_read(csr_addr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_we = 1'b1;
        step(1);
        csr_we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(nm, csr_rdata, exp);
    endtask

    task automatic trap(input logic [PC_W-1:0] p, input logic [2:0] e);
        trap_enter = 1'b1; pc = p; exceptions = e;
        step(1);
        trap_enter = 1'b0; exceptions = 3'b000;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        step(1);
        mret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_timer = 0; irq_ext = 0; irq_in = '0; exceptions = 0;
        trap_enter = 0; mret = 0; pc = '0; csr_addr = '0; csr_wdata = '0; csr_we = 0;
        step(3);
        reset = 1'b0;

        // Reset values
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h1);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);
        step(1);
        rd("rst_unmapped", 12'h7C0, 32'h0);
        check("rst_pending", 32'(interrupt_pending), 32'h0);
        check("rst_isr_return", 32'(isr_return), 32'h0);

        // External edge interrupt, then trap entry
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        irq_ext = 1'b1;
        step(1);
        irq_ext = 1'b0;
        step(1);
        check("ext_pend_early", 32'(interrupt_pending), 32'h0);
        step(1);
        check("ext_pend_3cyc", 32'(interrupt_pending), 32'h1);
        trap(16'h0120, 3'b000);
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_mepc", 12'h341, 32'h120);
        rd("ext_mstatus", 12'h300, 32'h80);
        rd("ext_mip", 12'h344, 32'h0);
        check("ext_target", 32'(isr_target), 32'h2C);

        // Level platform source beats the timer
        do_mret();
        rd("mret1_mstatus", 12'h300, 32'h88);
        wr(12'h304, 32'h0004_0080);
        irq_timer = 1'b1; irq_in = 4'b0100;
        step(2);
        check("lvl_pending", 32'(interrupt_pending), 32'h1);
        rd("lvl_mip", 12'h344, 32'h0004_0080);
        trap(16'h0300, 3'b000);
        rd("lvl_mcause", 12'h342, 32'h8000_0012);
        check("lvl_target", 32'(isr_target), 32'h48);
        do_mret();
        rd("mret2_mstatus", 12'h300, 32'h88);
        irq_timer = 1'b0; irq_in = 4'b0000;
        step(2);
        check("lvl_gone", 32'(interrupt_pending), 32'h0);

        // Only sticky mip bits are software-writable
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_all_ones", 12'h344, 32'h0001_0800);
        wr(12'h344, 32'h0);
        rd("mip_zero", 12'h344, 32'h0);

        // Trap beats a same-cycle mepc write; exception causes
        wr(12'h305, 32'h101);
        csr_addr = 12'h341; csr_wdata = 32'h444; csr_we = 1'b1;
        trap(16'h0200, 3'b010);
        csr_we = 1'b0;
        rd("exc_mepc", 12'h341, 32'h200);
        rd("exc_mcause", 12'h342, 32'h2);
        rd("exc_mstatus", 12'h300, 32'h80);
        check("exc_target", 32'(isr_target), 32'h100);
        trap(16'h0210, 3'b101);
        rd("exc0_mcause", 12'h342, 32'h0);
        trap(16'h0220, 3'b100);
        rd("exc5_mcause", 12'h342, 32'h5);
        trap(16'h0203, 3'b000);
        rd("none_mcause", 12'h342, 32'h5);
        rd("none_mepc", 12'h341, 32'h202);

        // External beats platform edge source 0; sticky bit 16 survives the first trap
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h0001_0880);
        irq_ext = 1'b1; irq_in = 4'b0001;
        step(1);
        irq_ext = 1'b0; irq_in = 4'b0000;
        step(2);
        check("both_pending", 32'(interrupt_pending), 32'h1);
        rd("both_mip", 12'h344, 32'h0001_0800);
        trap(16'h0400, 3'b000);
        rd("both_mcause", 12'h342, 32'h8000_000B);
        rd("both_mip_after", 12'h344, 32'h0001_0000);
        do_mret();
        check("p16_pending", 32'(interrupt_pending), 32'h1);
        trap(16'h0410, 3'b000);
        rd("p16_mcause", 12'h342, 32'h8000_0010);
        rd("p16_mip", 12'h344, 32'h0);
        check("p16_target", 32'(isr_target), 32'h140);
        check("p16_return", 32'(isr_return), 32'h410);

        // Reset wins over trap and mret in the same cycle
        reset = 1'b1; trap_enter = 1'b1; mret = 1'b1; pc = 16'h0666;
        step(1);
        reset = 1'b0; trap_enter = 1'b0; mret = 1'b0;
        rd("rst2_mstatus", 12'h300, 32'h0);
        rd("rst2_mepc", 12'h341, 32'h0);
        rd("rst2_mcause", 12'h342, 32'h0);
        rd("rst2_mtvec", 12'h305, 32'h1);

`ifdef CSR_MCYCLE_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        step(1);
        rd("mcycle_hi", 12'hB80, 32'h1);
        rd("mcycle_lo", 12'hB00, 32'h0);
`else
        rd("mcycle_lo_unmapped", 12'hB00, 32'h0);
        rd("mcycle_hi_unmapped", 12'hB80, 32'h0);
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
- Parametrised machine-mode CSR and interrupt unit for the tinyrv core.
- Holds mstatus, mie, mtvec, mepc, mcause and mip, and synchronises the interrupt sources.
- Arbitrates the pending interrupts by fixed priority and latches the cause at trap entry.
- Computes the direct or vectored ISR target. NUM_IRQ platform sources are generalised; each can be level- or edge-sensitive, and MIE/MPIE are stacked properly.

Parameters:
- NUM_IRQ, 4: number of platform interrupt sources; source i maps to mip/mie bit 16+i (1..16).
- IRQ_EDGE_MASK, 4'b0001: bit i=1 makes source i edge-triggered (sticky); bit i=0 makes it level-sensitive.
- PC_W, 16: PC width.
- SYNC_STAGES, 2: synchroniser depth for irq_ext and irq_in (at least 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_timer  in  1  timer interrupt, level, already synchronous (mip[7])
- irq_ext  in  1  external interrupt, asynchronous, edge/sticky (mip[11])
- irq_in  in  NUM_IRQ  platform interrupts, asynchronous
- exceptions  in  3  [0] PC misaligned, [1] illegal instruction, [2] load access fault
- trap_enter  in  1  core takes the trap this cycle
- mret  in  1  core executes mret this cycle
- pc  in  PC_W  PC to save into mepc
- interrupt_pending  out  1  an enabled interrupt is pending and MIE=1
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_we  in  1  CSR write strobe
- csr_rdata  out  32  CSR read data, combinational
- isr_return  out  PC_W  mepc[PC_W-1:0]
- isr_target  out  PC_W  trap vector

Behaviour:
- CSR map:
  - 0x300 mstatus: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - 0x304 mie
  - 0x305 mtvec: [1:0] mode, 0 = direct, 1 = vectored.
  - 0x341 mepc: bit 0 is forced to 0.
  - 0x342 mcause
  - 0x344 mip
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values: mstatus=0, mie=0, mtvec=32'h1, mepc=0, mcause=0, mip=0, all synchroniser flops 0.
  - Outputs after reset: interrupt_pending=0, isr_return=0.
  - Reset during a trap or mret cycle wins over everything.
- Synchronisers: irq_ext and irq_in pass through SYNC_STAGES flops. Latency from input to mip is SYNC_STAGES+1 cycles for edge sources and SYNC_STAGES cycles for level sources.
- mip update rules:
  - mip[7] follows irq_timer every cycle.
  - Level sources: mip[16+i] follows the synchronised input every cycle; these bits are read-only.
  - Edge sources (and mip[11]): the bit is set on a synchronised 0→1 transition. It clears on a software write of 0, or automatically on trap_enter when its cause is the one being taken.
  - Set beats clear in the same cycle.
- Arbitration (combinational), highest priority first:
  - 11 (external)
  - 16+i, lowest i first
  - 7 (timer)
  - then exceptions: [1] → code 2, [0] → code 0, [2] → code 5.
  - An interrupt is eligible when mie bit & mip bit & mstatus.MIE.
  - interrupt_pending = OR of all eligible interrupts.
- trap_enter (effects visible the next cycle):
  - mepc ← pc
  - mcause ← arbitrated cause; bit 31 = 1 for interrupts.
  - MPIE ← MIE, MIE ← 0
  - If trap_enter fires with nothing eligible and no exception, mcause is unchanged.
- mret: MIE ← MPIE, MPIE ← 1. If trap_enter and mret arrive together, trap_enter wins.
- CSR write in the same cycle as trap_enter or mret: trap/mret updates to mstatus, mepc and mcause win. Writes to other CSRs proceed.
- isr_target is computed from the registered mcause:
  - Vectored mode with an interrupt cause: mtvec[31:2]·4 + 4·code.
  - Otherwise: mtvec[31:2]·4.
  - The result is truncated to PC_W.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- When defined:
  - A 64-bit mcycle counter increments every cycle after reset.
  - Reads at 0xB00 return the low word; reads at 0xB80 return the high word.
  - Writes load the addressed half, and the counter does not increment in that cycle.
  - The counter wraps to 0 past all-ones.
- When undefined: 0xB00 and 0xB80 are unmapped and read 0.

Test Plan:
- Reset, then read every CSR → mtvec=1, all others 0; interrupt_pending=0.
- Write mie=1<<11 and mstatus=8, then pulse irq_ext for 1 cycle → interrupt_pending=1 three cycles later.
  - Then trap_enter with pc=0x0120 → mcause=0x8000000B, mepc=0x120, mstatus=0x80, mip[11]=0, isr_target=0x2C with mtvec=1.
- irq_timer and irq_in[2] (level) both pending and enabled → trap_enter gives mcause=0x80000012.
  - A subsequent mret restores mstatus=0x88.
- Write mip=0xFFFFFFFF → only edge bits 11 and 16 change; writing 0 clears them.
- trap_enter and csr_we to mepc (0x0444) in the same cycle with pc=0x0200 → mepc=0x200.
  - Same-cycle exceptions[1] with no interrupt → mcause=2, isr_target=mtvec base.
- With CSR_MCYCLE_EN: write 0xB00=0xFFFFFFFF, 0xB80=0 → two cycles later, reading 0xB80 returns 1.
